// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, the XZR register number
// and the packed per-stage control word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_e;

    localparam logic [4:0] XZR = 5'd31;

    // en: {ifid, idex, exmem, memwb}; flush: {ifid, idex, exmem}
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [2:0] flush;
    } ctrl_t;

    function automatic logic load_use_hit(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic       uses_rn,
        input logic [4:0] rn,
        input logic       uses_rm,
        input logic [4:0] rm
    );
        return ex_memread && (ex_rd != XZR) &&
               ((uses_rn && (rn == ex_rd)) || (uses_rm && (rm == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and per-stage enable/flush outputs for pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       mem_br_taken;
    logic       mem_busy;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_flush;
    logic       exmem_en;
    logic       exmem_flush;
    logic       memwb_en;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memread, ex_rd, mem_br_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_memread, ex_rd, mem_br_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencing: post-reset bubble fill, memory freeze, taken-branch squash
// and load-use stall, with saturating perf counters for each event.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FILL_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     freeze_cnt
);

    localparam int FILL_W = $clog2(FILL_CYCLES + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    ctrl_t             ctrl;
    logic              hazard;
    logic              stall_inc;
    logic              flush_inc;
    logic              freeze_inc;

    assign hazard = load_use_hit(bus.ex_memread, bus.ex_rd, bus.id_uses_rn, bus.id_rn,
                                 bus.id_uses_rm, bus.id_rm);

    // rst is folded in here so outputs drop to the reset pattern the instant it rises.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        ctrl       = '{pc_en: 1'b0, en: 4'b0000, flush: 3'b111};
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        freeze_inc = 1'b0;
        if (!rst) begin
            case (state_q)
                FILL: begin
                    ctrl = '{pc_en: 1'b0, en: 4'b1111, flush: 3'b111};
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                RUN, FREEZE: begin
                    state_d = RUN;
                    if (bus.mem_busy) begin
                        ctrl       = '{pc_en: 1'b0, en: 4'b0000, flush: 3'b000};
                        state_d    = FREEZE;
                        freeze_inc = 1'b1;
                    end else if (bus.mem_br_taken) begin
                        ctrl      = '{pc_en: 1'b1, en: 4'b1111, flush: 3'b111};
                        flush_inc = 1'b1;
                    end else if (hazard) begin
                        ctrl      = '{pc_en: 1'b0, en: 4'b0111, flush: 3'b010};
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = '{pc_en: 1'b1, en: 4'b1111, flush: 3'b000};
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.ifid_en     = ctrl.en[3];
    assign bus.idex_en     = ctrl.en[2];
    assign bus.exmem_en    = ctrl.en[1];
    assign bus.memwb_en    = ctrl.en[0];
    assign bus.ifid_flush  = ctrl.flush[2];
    assign bus.idex_flush  = ctrl.flush[1];
    assign bus.exmem_flush = ctrl.flush[0];

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_inc),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of RUN-state vectors plus hand-written
// fill, freeze, mid-freeze reset and counter saturation sequences.
module tb_pipe_hazard_ctrl;

    localparam int FILL_CYCLES = 4;
    localparam int CNT_W       = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [7:0] C_RESET  = 8'b0_0000_111;
    localparam logic [7:0] C_FILL   = 8'b0_1111_111;
    localparam logic [7:0] C_FREEZE = 8'b0_0000_000;
    localparam logic [7:0] C_BRANCH = 8'b1_1111_111;
    localparam logic [7:0] C_STALL  = 8'b0_0111_010;
    localparam logic [7:0] C_NORMAL = 8'b1_1111_000;

    typedef struct {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [7:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    logic [CNT_W-1:0] exp_stall, exp_flush, exp_freeze;
    logic [7:0] exp_q[$];
    int n_checks;
    int n_fail;

    vec_t vecs[13];
    vec_t v_idle, v_busy, v_br, v_stall;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(
        .FILL_CYCLES (FILL_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .freeze_cnt (freeze_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == CMAX) ? c : c + 1'b1;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.id_rn        = v.rn;
        bus.id_rm        = v.rm;
        bus.id_uses_rn   = v.urn;
        bus.id_uses_rm   = v.urm;
        bus.ex_memread   = v.memread;
        bus.ex_rd        = v.rd;
        bus.mem_br_taken = v.br;
        bus.mem_busy     = v.busy;
        exp_q.push_back(v.exp);
        if (v.exp == C_STALL)  exp_stall  = satInc(exp_stall);
        if (v.exp == C_BRANCH) exp_flush  = satInc(exp_flush);
        if (v.exp == C_FREEZE) exp_freeze = satInc(exp_freeze);
    endtask

    task automatic checkOutput(input string name);
        logic [7:0] act;
        logic [7:0] expv;
        act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: ctrl=%b but no expected entry queued", name, act);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                n_fail++;
                $display("[TB] FAIL %s: ctrl got %b expected %b", name, act, expv);
            end
        end
    endtask

    task automatic checkCount(input string name, input logic [CNT_W-1:0] act,
                              input logic [CNT_W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic checkCounters(input string name);
        checkCount({name, ".stall_cnt"},  stall_cnt,  exp_stall);
        checkCount({name, ".flush_cnt"},  flush_cnt,  exp_flush);
        checkCount({name, ".freeze_cnt"}, freeze_cnt, exp_freeze);
    endtask

    // Drive one cycle, compare combinational outputs mid-cycle, counters after the edge.
    task automatic step(input vec_t v, input string name);
        applyStimulus(v);
        #2;
        checkOutput(name);
        @(posedge clk);
        #1;
        checkCounters(name);
    endtask

    task automatic fillSeq(input string name);
        vec_t v;
        v = v_busy;
        v.br = 1'b1;
        v.exp = C_FILL;
        for (int i = 0; i < FILL_CYCLES; i++) begin
            step(v, $sformatf("%s.fill%0d", name, i));
        end
        step(v_idle, {name, ".run_after_fill"});
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_stall  = '0;
        exp_flush  = '0;
        exp_freeze = '0;

        v_idle  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_NORMAL};
        v_busy  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE};
        v_br    = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, C_BRANCH};
        v_stall = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, C_STALL};

        vecs[0]  = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, C_NORMAL};
        vecs[1]  = '{5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 5'd3,  1'b0, 1'b0, C_STALL};
        vecs[2]  = '{5'd31, 5'd4,  1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, C_NORMAL};
        vecs[3]  = '{5'd3,  5'd4,  1'b1, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0, C_NORMAL};
        vecs[4]  = '{5'd1,  5'd7,  1'b1, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, C_STALL};
        vecs[5]  = '{5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, C_NORMAL};
        vecs[6]  = '{5'd7,  5'd7,  1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, C_NORMAL};
        vecs[7]  = '{5'd3,  5'd4,  1'b1, 1'b1, 1'b1, 5'd3,  1'b1, 1'b0, C_BRANCH};
        vecs[8]  = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, C_BRANCH};
        vecs[9]  = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, C_FREEZE};
        vecs[10] = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, C_FREEZE};
        vecs[11] = '{5'd9,  5'd6,  1'b0, 1'b1, 1'b1, 5'd6,  1'b0, 1'b0, C_STALL};
        vecs[12] = '{5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, C_NORMAL};

        rst = 1'b1;
        v_idle.exp = C_RESET;
        #1;
        step(v_idle, "reset");
        v_idle.exp = C_NORMAL;
        rst = 1'b0;
        fillSeq("initial");

        for (int i = 0; i < 13; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Three frozen cycles, then a taken branch squashes in the release cycle.
        for (int i = 0; i < 3; i++) begin
            step(v_busy, $sformatf("freeze%0d", i));
        end
        step(v_br, "freeze_release_branch");
        step(v_idle, "after_release");

        // Asynchronous reset while frozen.
        step(v_busy, "pre_reset_freeze");
        v_busy.exp = C_RESET;
        applyStimulus(v_busy);
        rst        = 1'b1;
        exp_stall  = '0;
        exp_flush  = '0;
        exp_freeze = '0;
        #2;
        checkOutput("async_reset");
        checkCounters("async_reset");
        @(posedge clk);
        #1;
        applyStimulus(v_busy);
        #2;
        checkOutput("reset_held");
        v_busy.exp = C_FREEZE;
        rst = 1'b0;
        fillSeq("refill");

        // Back-to-back stalls drive the narrow counter to saturation.
        for (int i = 0; i < int'(CMAX) + 1; i++) begin
            step(v_stall, $sformatf("sat%0d", i));
        end
        checkCount("stall_saturated", stall_cnt, CMAX);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
